// File: rtl/romatrix_pkg.sv
// Shared types for the ring-oscillator matrix scheduler: FSM state encoding
// and the oscillator-select width helper.
package romatrix_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  // Select width is max(1, clog2(n)) so a single-oscillator matrix still has a 1-bit index.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises the asynchronous oscillator output, detects rising edges and
// accumulates them in a saturating counter.
module ro_edge_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             count_en,
  input  logic             ro_out,
  output logic [CNT_W-1:0] count
);

  logic sync1;
  logic sync2;
  logic dly;
  logic rise;

  assign rise = sync2 & ~dly;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
      count <= '0;
    end else begin
      sync1 <= ro_out;
      sync2 <= sync1;
      dly   <= sync2;
      // Hold at all-ones rather than wrapping so an overfast oscillator reads as "at least max".
      if (clear) begin
        count <= '0;
      end else if (count_en && rise && (count != '1)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/romatrix_scheduler.sv
// Scans N_OSC ring oscillators: settle, count edges over a fixed window, hand the
// result out on a valid/ready port. Optional ROMATRIX_SCHED_CONTINUOUS_EN restarts the scan.
module romatrix_scheduler
  import romatrix_pkg::*;
#(
  parameter int N_OSC         = 10,
  parameter int SETTLE_CYCLES = 4,
  parameter int RESOL_CYCLES  = 1024,
  parameter int CNT_W         = 32,
  localparam int SW           = sel_width(N_OSC)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             ro_out,
  output logic [SW-1:0]    sel_ro,
  output logic             enable,
  output logic [CNT_W-1:0] data_out,
  output logic [SW-1:0]    data_idx,
  output logic             data_valid,
  input  logic             data_ready,
`ifdef ROMATRIX_SCHED_CONTINUOUS_EN
  input  logic             continuous,
`endif
  output logic             busy,
  output logic             done
);

  // Handshake: a result transfers on a rising clock edge where data_valid & data_ready;
  // data_out/data_idx stay stable while data_valid is high and not yet accepted.

  localparam int TMAX = (SETTLE_CYCLES > RESOL_CYCLES) ? SETTLE_CYCLES : RESOL_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [SW-1:0] LAST_IDX    = SW'(N_OSC - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] RESOL_LAST  = TW'(RESOL_CYCLES - 1);

  state_t           state;
  logic [SW-1:0]    idx;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] count;
  logic             wrap;
  logic             cnt_clear;
  logic             cnt_en;

`ifdef ROMATRIX_SCHED_CONTINUOUS_EN
  assign wrap = continuous;
`else
  assign wrap = 1'b0;
`endif

  assign cnt_clear = (state == S_SETTLE);
  assign cnt_en    = (state == S_MEASURE);
  // Counter stops in OUTPUT, so its register is the stable result.
  assign data_out  = count;

  ro_edge_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear),
    .count_en(cnt_en),
    .ro_out  (ro_out),
    .count   (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      timer      <= '0;
      sel_ro     <= '0;
      data_idx   <= '0;
      enable     <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_SETTLE;
            idx    <= '0;
            sel_ro <= '0;
            timer  <= '0;
            enable <= 1'b1;
            busy   <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (timer == SETTLE_LAST) begin
            state <= S_MEASURE;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_MEASURE: begin
          if (timer == RESOL_LAST) begin
            state      <= S_OUTPUT;
            timer      <= '0;
            enable     <= 1'b0;
            data_valid <= 1'b1;
            data_idx   <= idx;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_OUTPUT: begin
          if (data_ready) begin
            data_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              done <= 1'b1;
              if (wrap) begin
                state  <= S_SETTLE;
                idx    <= '0;
                sel_ro <= '0;
                enable <= 1'b1;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              // sel_ro moves together with enable rising: the SETTLE entry cycle.
              state  <= S_SETTLE;
              idx    <= idx + 1'b1;
              sel_ro <= idx + 1'b1;
              enable <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/romatrix_scheduler.md
ROMATRIX_SCHEDULER -- requirements
Module: romatrix_scheduler

Interface
REQ-001 SHALL have parameter N_OSC, default 10, number of ring oscillators in the matrix.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, cycles the oscillator runs before counting.
REQ-003 SHALL have parameter RESOL_CYCLES, default 1024, length of the counting window in cycles.
REQ-004 SHALL have parameter CNT_W, default 32, count width.
REQ-005 SHALL have the following ports (SW = max(1, clog2(N_OSC))):
  clock  in  1  single system clock, all logic on its rising edge
  reset  in  1  synchronous, active-high
  start  in  1  one-cycle request for a full scan, honoured only in IDLE
  ro_out  in  1  selected oscillator output from the matrix interface, asynchronous
  sel_ro  out  SW  oscillator index driven to the matrix interface
  enable  out  1  run strobe to the matrix interface
  data_out  out  CNT_W  edge count of the finished window
  data_idx  out  SW  oscillator index belonging to data_out
  data_valid  out  1  data_out/data_idx valid
  data_ready  in  1  consumer accepts when data_valid & data_ready
  busy  out  1  high in every state except IDLE
  done  out  1  one-cycle pulse after the last result is accepted

Function
REQ-006 SHALL implement states IDLE, SETTLE, MEASURE, OUTPUT.
REQ-007 IDLE: start=1 -> SETTLE with index 0; start in any other state SHALL be ignored.
REQ-008 SETTLE: enable=1, sel_ro=index, edge counter cleared; exactly SETTLE_CYCLES cycles, then MEASURE.
REQ-009 MEASURE: enable=1; exactly RESOL_CYCLES cycles; counter increments once per detected rising edge, then OUTPUT.
REQ-010 Edge detection SHALL use a 2-flop synchronizer plus a delay flop; an edge is counted when the detection cycle falls inside MEASURE.
REQ-011 Counter SHALL saturate at all-ones, never wrap.
REQ-012 OUTPUT: enable=0, data_valid=1, data_out/data_idx stable until the handshake.
REQ-013 On handshake with index<N_OSC-1: index+1, -> SETTLE the next cycle, data_valid drops.
REQ-014 On handshake with index=N_OSC-1: done=1 for one cycle, -> IDLE.
REQ-015 sel_ro SHALL change only while enable=0 or at the SETTLE entry cycle, never during MEASURE.
REQ-016 N_OSC=1 SHALL work with SW=1 and index held at 0.

Reset
REQ-017 reset SHALL dominate all inputs, in any state including mid-MEASURE or mid-OUTPUT.
REQ-018 Next cycle after reset: state IDLE; sel_ro, data_idx, data_out, counter and index 0; enable, data_valid, busy, done 0; synchronizer flops 0.

Configuration
REQ-019 Macro ROMATRIX_SCHED_CONTINUOUS_EN defined:
  - adds input port continuous (1 bit).
  - at the REQ-014 handshake, continuous=1 SHALL pulse done and go to SETTLE with index 0 instead of IDLE.
REQ-020 Macro undefined: port absent; behaviour per REQ-014 only.

Structure
REQ-021 Shared package romatrix_pkg SHALL hold the state enum and the SW width function.
REQ-022 Synchronizer, edge detector and saturating counter SHALL be sub-module ro_edge_counter (inputs clear, count_en, ro_out; output count).

Verification
REQ-023 Bench (N_OSC=4, SETTLE=2, RESOL=16, CNT_W=8, ro_out period 4 clocks, data_ready=1) SHALL cover:
  - Basic scan: start -> four results, data_idx 0,1,2,3, each data_out=4 (+/-1); done one cycle after the 4th handshake; busy then 0.
  - Backpressure: data_ready=0 for 10 cycles in OUTPUT -> data_valid held, data_out stable, enable=0, no index advance.
  - Saturation: CNT_W=3, ro_out period 2 -> data_out=7.
  - Reset mid-MEASURE on index 2 -> next cycle enable=0, busy=0, sel_ro=0; a following start rescans from index 0.
  - Start ignored: pulse start during SETTLE of index 1 -> scan unaffected, still exactly 4 results.
  - ROMATRIX_SCHED_CONTINUOUS_EN, continuous=1 -> after data_idx=3: done pulse, next result data_idx=0, busy stays 1.
